// File: rtl/phy_regfile_wb_arbiter.sv
// Writeback arbiter: one holding buffer per requester, round-robin onto the single
// physical-register-file write port, with the registered write mirrored as a wakeup tag.
module phy_regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DROP_PREG0 = 1,
  parameter int unsigned PREG_W     = 6,
  parameter int unsigned VAL_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_phy_reg,
  input  logic [NUM_REQ*VAL_W-1:0]  req_val,
  output logic                      commit_wr_en,
  output logic [PREG_W-1:0]         wr_commit_reg,
  output logic [VAL_W-1:0]          commit_wr_val,
  output logic                      wakeup_valid,
  output logic [PREG_W-1:0]         wakeup_tag,
  output logic [NUM_REQ-1:0]        buf_full
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_full_q, buf_full_d;
  logic [PREG_W-1:0]  buf_reg_q [NUM_REQ];
  logic [PREG_W-1:0]  buf_reg_d [NUM_REQ];
  logic [VAL_W-1:0]   buf_val_q [NUM_REQ];
  logic [VAL_W-1:0]   buf_val_d [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [PREG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [VAL_W-1:0]   wr_val_q, wr_val_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] accept;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin pick of the first full buffer at or after rr_ptr; depends on state only.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && buf_full_q[wrap_add(rr_ptr_q, k)]) begin
        gnt_idx                        = wrap_add(rr_ptr_q, k);
        gnt[wrap_add(rr_ptr_q, k)]     = 1'b1;
        gnt_any                        = 1'b1;
      end
    end
  end

  assign req_ready = ~buf_full_q | gnt;
  assign accept    = req_valid & req_ready;

  always_comb begin
    buf_full_d = (buf_full_q & ~gnt) | accept;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      buf_reg_d[i] = buf_reg_q[i];
      buf_val_d[i] = buf_val_q[i];
      if (accept[i]) begin
        buf_reg_d[i] = req_phy_reg[i*PREG_W +: PREG_W];
        buf_val_d[i] = req_val[i*VAL_W +: VAL_W];
      end
    end

    rr_ptr_d = rr_ptr_q;
    wr_en_d  = 1'b0;
    wr_reg_d = wr_reg_q;
    wr_val_d = wr_val_q;
    if (gnt_any) begin
      rr_ptr_d = wrap_add(gnt_idx, 1);
      // Writes to preg 0 drain silently and leave the port contents untouched.
      if (!((DROP_PREG0 != 0) && (buf_reg_q[gnt_idx] == '0))) begin
        wr_en_d  = 1'b1;
        wr_reg_d = buf_reg_q[gnt_idx];
        wr_val_d = buf_val_q[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_full_q <= '0;
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_val_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_reg_q[i] <= '0;
        buf_val_q[i] <= '0;
      end
    end else begin
      buf_full_q <= buf_full_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_val_q   <= wr_val_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_reg_q[i] <= buf_reg_d[i];
        buf_val_q[i] <= buf_val_d[i];
      end
    end
  end

  assign commit_wr_en  = wr_en_q;
  assign wr_commit_reg = wr_reg_q;
  assign commit_wr_val = wr_val_q;
  assign wakeup_valid  = wr_en_q;
  assign wakeup_tag    = wr_reg_q;
  assign buf_full      = buf_full_q;

endmodule

// File: tb/tb_phy_regfile_wb_arbiter.sv
// Bench for phy_regfile_wb_arbiter: directed scenarios then random traffic, all
// compared each cycle against a queue-style reference of the arbitration rules.
module tb_phy_regfile_wb_arbiter;

  localparam int N  = 2;
  localparam int PW = 6;
  localparam int VW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*PW-1:0] req_phy_reg;
  logic [N*VW-1:0] req_val;
  logic            commit_wr_en;
  logic [PW-1:0]   wr_commit_reg;
  logic [VW-1:0]   commit_wr_val;
  logic            wakeup_valid;
  logic [PW-1:0]   wakeup_tag;
  logic [N-1:0]    buf_full;

  phy_regfile_wb_arbiter #(.NUM_REQ(N), .DROP_PREG0(1), .PREG_W(PW), .VAL_W(VW)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_phy_reg(req_phy_reg), .req_val(req_val), .commit_wr_en(commit_wr_en),
    .wr_commit_reg(wr_commit_reg), .commit_wr_val(commit_wr_val),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: each requester holds at most one pending write; the port holds the last write.
  bit          m_full [N];
  int unsigned m_reg  [N];
  int unsigned m_val  [N];
  int          m_ptr;
  bit          m_en;
  int unsigned m_wreg, m_wval;
  bit          m_acc  [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_gnt();
    for (int k = 0; k < N; k++)
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input int unsigned r, input int unsigned d);
    req_valid[i]            = v;
    req_phy_reg[i*PW +: PW] = PW'(r);
    req_val[i*VW +: VW]     = VW'(d);
  endtask

  // Called at a negedge with inputs applied: compare, advance model, stop at the next negedge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready, exp_full;
    #1;
    g = model_gnt();
    for (int i = 0; i < N; i++) begin
      exp_full[i]  = m_full[i];
      exp_ready[i] = !m_full[i] || (g == i);
    end
    check("buf_full",      64'(buf_full),      64'(exp_full));
    check("req_ready",     64'(req_ready),     64'(exp_ready));
    check("commit_wr_en",  64'(commit_wr_en),  64'(m_en));
    check("wr_commit_reg", 64'(wr_commit_reg), 64'(m_wreg));
    check("commit_wr_val", 64'(commit_wr_val), 64'(m_wval));
    check("wakeup_valid",  64'(wakeup_valid),  64'(m_en));
    check("wakeup_tag",    64'(wakeup_tag),    64'(m_wreg));
    for (int i = 0; i < N; i++) m_acc[i] = rst && req_valid[i] && exp_ready[i];
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) begin m_full[i] = 0; m_reg[i] = 0; m_val[i] = 0; end
      m_ptr = 0; m_en = 0; m_wreg = 0; m_wval = 0;
    end else begin
      m_en = 0;
      if (g >= 0) begin
        if (m_reg[g] != 0) begin m_en = 1; m_wreg = m_reg[g]; m_wval = m_val[g]; end
        m_full[g] = 0;
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (m_acc[i]) begin
          m_full[i] = 1;
          m_reg[i]  = 32'(req_phy_reg[i*PW +: PW]);
          m_val[i]  = 32'(req_val[i*VW +: VW]);
        end
    end
    @(negedge clk);
  endtask

  initial begin
    bit          pend  [N];
    int unsigned p_reg [N];
    int unsigned p_val [N];
    int          n;

    for (int i = 0; i < N; i++) begin m_full[i] = 0; m_reg[i] = 0; m_val[i] = 0; pend[i] = 0; end
    m_ptr = 0; m_en = 0; m_wreg = 0; m_wval = 0;
    rst = 1'b0; req_valid = '0; req_phy_reg = '0; req_val = '0;
    @(negedge clk);

    // T1: reset held with both requesters valid
    set_req(0, 1, 1, 32'h11); set_req(1, 1, 2, 32'h22);
    repeat (3) cycle();
    rst = 1'b1; req_valid = '0;
    cycle();
    check("t1_ready_after_release", 64'(req_ready), 64'h3);

    // T2: single write, two-cycle latency
    set_req(0, 1, 5, 32'hDEAD);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // T3: continuous contention from reset
    rst = 1'b0; cycle(); rst = 1'b1;
    set_req(0, 1, 3, 32'h300); set_req(1, 1, 4, 32'h400);
    repeat (10) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // T4: lone requester streaming regs 1..8
    rst = 1'b0; cycle(); rst = 1'b1;
    n = 1;
    for (int it = 0; it < 30 && n <= 8; it++) begin
      set_req(0, 1, n, 32'h1000 + n);
      cycle();
      if (m_acc[0]) n++;
    end
    check("t4_all_accepted", 64'(n), 64'd9);
    req_valid = '0;
    repeat (3) cycle();

    // T5: preg0 write drains silently, next write proceeds
    set_req(1, 1, 0, 7);
    cycle();
    set_req(1, 1, 9, 32'h99);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // T6: reset while both buffers full
    set_req(0, 1, 10, 32'hA0); set_req(1, 1, 11, 32'hB0);
    cycle();
    req_valid = '0; rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_buf_empty", 64'(buf_full), 64'h0);
    set_req(0, 1, 12, 32'hC0); set_req(1, 1, 13, 32'hD0);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Random traffic with hold-until-accepted requesters and occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1; p_reg[i] = $urandom_range(0, 7); p_val[i] = $urandom;
        end
        set_req(i, pend[i], p_reg[i], p_val[i]);
      end
      rst = ($urandom_range(0, 49) != 0);
      cycle();
      for (int i = 0; i < N; i++) if (m_acc[i]) pend[i] = 0;
    end
    rst = 1'b1; req_valid = '0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
